reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank: DEPTH entries of WIDTH bits behind a single valid/ready command port, with write, read and in-place read-modify-write operations (shift, rotate, increment) and a multi-cycle sweep clear. It is the generalised successor to the single 8-bit register project. It sits behind the TinyTapeout top-level wrapper, which maps ui_in/uio_in onto the command port and rd_data onto uo_out.

## Interface
- WIDTH, 8, data width of each entry (≥2)
- DEPTH, 4, number of entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bank can accept a command this cycle
- cmd_op  in  3  000 NOP, 001 WRITE, 010 READ, 011 SHL, 100 ROTL, 101 INC, 110 CLEAR_ALL, 111 reserved (treated as NOP)
- cmd_addr  in  ADDR_W  target entry
- cmd_data  in  WIDTH  write data (WRITE only)
- cmd_sin  in  1  serial bit shifted into LSB (SHL only)
- rd_valid  out  1  one-cycle pulse: rd_data/rd_flag carry a result
- rd_data  out  WIDTH  result value
- rd_flag  out  1  bit shifted/rotated out, or increment carry

## Operation
- A command is accepted on a rising edge when cmd_valid && cmd_ready. With cmd_ready low, cmd_valid is ignored and no state changes.
- States: IDLE and CLEAR. cmd_ready = 1 in IDLE and 0 in CLEAR.
- WRITE: entry[addr] <= cmd_data. No rd_valid.
- READ: rd_data <= entry[addr]; rd_flag <= 0; rd_valid pulses.
- SHL: entry[addr] <= {entry[addr][WIDTH-2:0], cmd_sin}; rd_flag <= old MSB; rd_data <= new value; rd_valid pulses.
- ROTL: entry[addr] <= {entry[addr][WIDTH-2:0], entry[addr][WIDTH-1]}; rd_flag <= old MSB; rd_data <= new value; rd_valid pulses.
- INC: entry[addr] <= entry[addr] + 1, computed modulo 2^WIDTH. rd_flag <= carry out (1 only when the old value was all ones, which wraps to 0). rd_data <= new value; rd_valid pulses.
- CLEAR_ALL: go to CLEAR with sweep index 0.
  - In CLEAR, each cycle clears entry[idx] and increments idx.
  - After clearing entry DEPTH-1, return to IDLE.
  - No rd_valid is produced.
- NOP and reserved opcodes: accepted, no effect.
- rd_data and rd_flag hold their last value while rd_valid is low.
- Reset (rst high at a rising edge) sets:
  - all entries to 0
  - state to IDLE and sweep index to 0
  - rd_valid=0, rd_data=0, rd_flag=0
  - cmd_ready=1 from the first cycle after reset
- Commands presented while rst is high are not accepted.
- Reset during CLEAR aborts the sweep immediately. All entries are zero regardless.

## Timing
- WRITE, SHL, ROTL, INC: accepted at edge T; the new entry value is visible from edge T onward. A READ of the same address accepted at edge T+1 returns the new value (back-to-back commands are allowed, throughput 1 per cycle).
- READ/SHL/ROTL/INC: rd_valid is high for exactly the cycle following acceptance edge T, with rd_data/rd_flag valid in that cycle.
- Back-to-back result commands give back-to-back rd_valid pulses.
- CLEAR_ALL accepted at edge T:
  - cmd_ready is low for cycles T+1 … T+DEPTH.
  - entry i reaches 0 at edge T+1+i.
  - cmd_ready returns high in cycle T+DEPTH+1.
  - Total occupancy is DEPTH+1 cycles, including the accept cycle.
- rd_valid is a registered output. cmd_ready is derived from registered state only, with no combinational path from cmd_valid.

## Test plan
- Reset then READ each address (DEPTH=4, WIDTH=8) -> four rd_valid pulses, each rd_data=0x00, rd_flag=0; cmd_ready=1 in the first cycle after reset.
- WRITE addr2=0x81, then SHL addr2 with sin=1 -> rd_data=0x03, rd_flag=1. Then ROTL addr2 -> rd_data=0x06, rd_flag=0.
- WRITE addr1=0xFF, then INC addr1 -> rd_data=0x00, rd_flag=1. INC again -> rd_data=0x01, rd_flag=0.
- Back-to-back: WRITE addr0=0x5A at edge T, READ addr0 at edge T+1 -> rd_valid in cycle T+2 with rd_data=0x5A; no idle cycles inserted.
- Load all entries with nonzero values, then CLEAR_ALL -> cmd_ready low for exactly 4 cycles, and cmd_valid READs held during that window are not accepted. Afterwards every READ returns 0x00.
- Assert rst mid-CLEAR (after 2 entries cleared) and deassert -> IDLE with cmd_ready=1 next cycle, all entries 0, and rd_valid stays 0 throughout.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank behind one valid/ready command port.
// Supports write, read, in-place shift/rotate/increment with a result pulse,
// and a multi-cycle sweep that clears one entry per cycle.
module reg_bank #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              cmd_sin,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_flag
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_WRITE = 3'b001,
        OP_READ  = 3'b010,
        OP_SHL   = 3'b011,
        OP_ROTL  = 3'b100,
        OP_INC   = 3'b101,
        OP_CLEAR = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  idx_reg, idx_next;

    logic               rd_valid_reg, rd_valid_next;
    logic [WIDTH-1:0]   rd_data_reg, rd_data_next;
    logic               rd_flag_reg, rd_flag_next;

    // Current contents of every entry, gathered from the per-entry registers.
    logic [DEPTH-1:0][WIDTH-1:0] entry_q;

    // Decoded command effects.
    logic               accept;
    logic               wr_en;
    logic               res_en;
    logic [WIDTH-1:0]   cur_val;
    logic [WIDTH-1:0]   new_val;
    logic               new_flag;
    logic [WIDTH:0]     inc_sum;
    op_t                op;

    // Ready depends only on the registered state, never on cmd_valid.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign op        = op_t'(cmd_op);
    assign cur_val   = entry_q[cmd_addr];
    assign inc_sum   = {1'b0, cur_val} + {{WIDTH{1'b0}}, 1'b1};

    // Opcode decode: new entry value, flag, and which side effects apply.
    always_comb begin
        new_val  = cur_val;
        new_flag = 1'b0;
        wr_en    = 1'b0;
        res_en   = 1'b0;
        case (op)
            OP_WRITE: begin
                new_val = cmd_data;
                wr_en   = 1'b1;
            end
            OP_READ: begin
                res_en  = 1'b1;
            end
            OP_SHL: begin
                new_val  = {cur_val[WIDTH-2:0], cmd_sin};
                new_flag = cur_val[WIDTH-1];
                wr_en    = 1'b1;
                res_en   = 1'b1;
            end
            OP_ROTL: begin
                new_val  = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
                new_flag = cur_val[WIDTH-1];
                wr_en    = 1'b1;
                res_en   = 1'b1;
            end
            OP_INC: begin
                new_val  = inc_sum[WIDTH-1:0];
                new_flag = inc_sum[WIDTH];
                wr_en    = 1'b1;
                res_en   = 1'b1;
            end
            default: begin
                // NOP, CLEAR_ALL and the reserved code touch no entry here.
            end
        endcase
    end

    // Next-state logic for the IDLE/CLEAR controller and the result port.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        rd_valid_next = 1'b0;
        rd_data_next  = rd_data_reg;
        rd_flag_next  = rd_flag_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_CLEAR) begin
                        state_next = ST_CLEAR;
                        idx_next   = '0;
                    end
                    if (res_en) begin
                        rd_valid_next = 1'b1;
                        rd_data_next  = new_val;
                        rd_flag_next  = new_flag;
                    end
                end
            end
            ST_CLEAR: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Controller and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_flag_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            rd_valid_reg <= rd_valid_next;
            rd_data_reg  <= rd_data_next;
            rd_flag_reg  <= rd_flag_next;
        end
    end

    // One register per entry; each is cleared by reset or by the sweep and
    // otherwise loaded only when an accepted command targets it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] val_reg;
            logic             sel;
            logic             sweep_hit;

            assign sel       = (cmd_addr == ADDR_W'(gi));
            assign sweep_hit = (state_reg == ST_CLEAR) && (idx_reg == ADDR_W'(gi));

            // Entry update: reset, sweep clear, or command write-back.
            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg <= '0;
                end else if (sweep_hit) begin
                    val_reg <= '0;
                end else if (accept && wr_en && sel) begin
                    val_reg <= new_val;
                end
            end

            assign entry_q[gi] = val_reg;
        end
    endgenerate

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign rd_flag  = rd_flag_reg;

endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank (WIDTH=8, DEPTH=4).
module tb_reg_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] WRITE = 3'b001;
    localparam logic [2:0] READ  = 3'b010;
    localparam logic [2:0] SHL   = 3'b011;
    localparam logic [2:0] ROTL  = 3'b100;
    localparam logic [2:0] INC   = 3'b101;
    localparam logic [2:0] CLR   = 3'b110;
    localparam logic [2:0] RSVD  = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_addr;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_sin;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_flag;

    int errors = 0;
    int checks = 0;

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_sin   (cmd_sin),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_flag   (rd_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command, step one edge, land 1 time unit after it.
    task automatic issue(input logic [2:0] op, input logic [1:0] addr,
                         input logic [7:0] data, input logic sin);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_sin   = sin;
        @(posedge clk);
        #1;
        $display("cmd op=%0d addr=%0d data=0x%02h sin=%0b -> rd_valid=%0b rd_data=0x%02h rd_flag=%0b ready=%0b",
                 op, addr, data, sin, rd_valid, rd_data, rd_flag, cmd_ready);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] d, input logic f);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"},  32'(rd_data),  32'(d));
        chk({tag, "_flag"},  32'(rd_flag),  32'(f));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_addr = '0; cmd_data = '0; cmd_sin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data",  32'(rd_data),  32'd0);
        chk("rst_flag",  32'(rd_flag),  32'd0);

        // Back-to-back reads of the reset contents.
        issue(READ, 2'd0, 8'h00, 1'b0); chk_res("rd_rst0", 8'h00, 1'b0);
        issue(READ, 2'd1, 8'h00, 1'b0); chk_res("rd_rst1", 8'h00, 1'b0);
        issue(READ, 2'd2, 8'h00, 1'b0); chk_res("rd_rst2", 8'h00, 1'b0);
        issue(READ, 2'd3, 8'h00, 1'b0); chk_res("rd_rst3", 8'h00, 1'b0);
        idle();
        chk("idle_valid", 32'(rd_valid), 32'd0);

        // Shift and rotate.
        issue(WRITE, 2'd2, 8'h81, 1'b0);
        chk("wr_novalid", 32'(rd_valid), 32'd0);
        issue(SHL,  2'd2, 8'h00, 1'b1); chk_res("shl", 8'h03, 1'b1);
        issue(ROTL, 2'd2, 8'h00, 1'b0); chk_res("rotl", 8'h06, 1'b0);
        idle();
        chk("hold_valid", 32'(rd_valid), 32'd0);
        chk("hold_data",  32'(rd_data),  32'h06);
        issue(ROTL, 2'd2, 8'h00, 1'b0); chk_res("rotl2", 8'h0C, 1'b0);
        issue(WRITE, 2'd3, 8'hC0, 1'b0);
        issue(ROTL, 2'd3, 8'h00, 1'b0); chk_res("rotl_msb", 8'h81, 1'b1);
        issue(SHL,  2'd3, 8'h00, 1'b0); chk_res("shl_sin0", 8'h02, 1'b1);

        // Increment with wrap and carry.
        issue(WRITE, 2'd1, 8'hFF, 1'b0);
        issue(INC, 2'd1, 8'h00, 1'b0); chk_res("inc_wrap", 8'h00, 1'b1);
        issue(INC, 2'd1, 8'h00, 1'b0); chk_res("inc_1", 8'h01, 1'b0);

        // Back-to-back write then read, then ignored opcodes.
        issue(WRITE, 2'd0, 8'h5A, 1'b0);
        issue(READ,  2'd0, 8'h00, 1'b0); chk_res("b2b", 8'h5A, 1'b0);
        issue(RSVD,  2'd0, 8'hFF, 1'b1);
        chk("rsvd_valid", 32'(rd_valid), 32'd0);
        issue(NOP,   2'd0, 8'hEE, 1'b1);
        chk("nop_valid", 32'(rd_valid), 32'd0);
        issue(READ,  2'd0, 8'h00, 1'b0); chk_res("after_nop", 8'h5A, 1'b0);
        issue(READ,  2'd2, 8'h00, 1'b0); chk_res("keep2", 8'h0C, 1'b0);

        // Full sweep clear with READs held off by cmd_ready.
        issue(WRITE, 2'd0, 8'h11, 1'b0);
        issue(WRITE, 2'd1, 8'h22, 1'b0);
        issue(WRITE, 2'd2, 8'h33, 1'b0);
        issue(WRITE, 2'd3, 8'h44, 1'b0);
        issue(READ,  2'd3, 8'h00, 1'b0); chk_res("load3", 8'h44, 1'b0);
        issue(CLR,   2'd0, 8'h00, 1'b0);
        cmd_op = READ; cmd_addr = 2'd0;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("clr_ready_low%0d", k), 32'(cmd_ready), 32'd0);
            chk($sformatf("clr_novalid%0d", k), 32'(rd_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("clr_ready_back", 32'(cmd_ready), 32'd1);
        chk("clr_held_rd", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        chk_res("clr_rd0", 8'h00, 1'b0);
        issue(READ, 2'd1, 8'h00, 1'b0); chk_res("clr_rd1", 8'h00, 1'b0);
        issue(READ, 2'd2, 8'h00, 1'b0); chk_res("clr_rd2", 8'h00, 1'b0);
        issue(READ, 2'd3, 8'h00, 1'b0); chk_res("clr_rd3", 8'h00, 1'b0);

        // Reset in the middle of a sweep; a write during reset is dropped.
        issue(WRITE, 2'd0, 8'hA1, 1'b0);
        issue(WRITE, 2'd1, 8'hA2, 1'b0);
        issue(WRITE, 2'd2, 8'hA3, 1'b0);
        issue(WRITE, 2'd3, 8'hA4, 1'b0);
        issue(CLR,   2'd0, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        chk("mid_novalid0", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_novalid1", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_novalid2", 32'(rd_valid), 32'd0);
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = WRITE; cmd_addr = 2'd3; cmd_data = 8'h77;
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = NOP;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        issue(READ, 2'd0, 8'h00, 1'b0); chk_res("mid_rd0", 8'h00, 1'b0);
        issue(READ, 2'd1, 8'h00, 1'b0); chk_res("mid_rd1", 8'h00, 1'b0);
        issue(READ, 2'd2, 8'h00, 1'b0); chk_res("mid_rd2", 8'h00, 1'b0);
        issue(READ, 2'd3, 8'h00, 1'b0); chk_res("mid_rd3", 8'h00, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
